// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the fetch-side PC sequencing controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_REDIR = 1'b1;

endpackage

// File: rtl/pc_flow_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pc_flow_ctrl.sv
// PC advance/hold/redirect sequencer with IF/ID and ID/EX stall/flush controls.
// Moore outputs per state; only the RUN-state load-use stall is Mealy.
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_hazard,
  input  logic             br_resolved,
  input  logic             BrTaken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_e          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            halt_pend_q, halt_pend_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic            stall_inc, redir_inc;
  logic            taken;

  assign taken = br_resolved & BrTaken;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    halt_pend_d = halt_pend_q;
    redir_pc_d  = redir_pc_q;
    pc_we       = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (taken) begin
          // Taken branch outranks both the stall and a halt; the halt waits.
          redir_pc_d = br_target;
          state_d    = ST_REDIRECT;
          if (halt_req) halt_pend_d = 1'b1;
        end else begin
          if (load_use_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
          if (halt_req || halt_pend_q) begin
            state_d     = ST_HALT;
            halt_pend_d = 1'b0;
          end
        end
      end
      ST_REDIRECT: begin
        pc_sel      = PC_SEL_REDIR;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        redir_inc   = 1'b1;
        halt_pend_d = halt_pend_q | halt_req;
        if (FLUSH_SLOTS == 1) begin
          state_d = ST_RUN;
        end else begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 3'(FLUSH_SLOTS - 1);
        end
      end
      ST_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        halt_pend_d = halt_pend_q | halt_req;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q == 3'd1) state_d = ST_RUN;
      end
      ST_HALT: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      halt_pend_q <= 1'b0;
      redir_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      halt_pend_q <= halt_pend_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  assign redirect_pc = redir_pc_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redir_inc),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Randomized + directed bench for pc_flow_ctrl against a slot-counting reference model.
module tb_pc_flow_ctrl;

  localparam int FS   = 2;
  localparam int CMAX = 255;

  logic        clk = 1'b0;
  logic        reset, load_use_hazard, br_resolved, BrTaken, halt_req;
  logic [15:0] br_target;
  logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted;
  logic [15:0] redirect_pc;
  logic [7:0]  stall_cnt, redirect_cnt;

  pc_flow_ctrl #(.PC_W(16), .FLUSH_SLOTS(FS), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_hazard (load_use_hazard),
    .br_resolved     (br_resolved),
    .BrTaken         (BrTaken),
    .br_target       (br_target),
    .halt_req        (halt_req),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .redirect_pc     (redirect_pc),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: m_slot counts position inside the post-branch window (1 = redirect cycle).
  int          m_slot = 0;
  bit          m_halt = 0, m_pend = 0;
  logic [15:0] m_tgt = '0;
  int          m_stall = 0, m_redir = 0;

  task automatic cyc(input bit r, input bit l, input bit b, input bit t,
                     input logic [15:0] g, input bit h);
    logic [5:0] e_ctl;
    bit         tk, st;
    reset = r; load_use_hazard = l; br_resolved = b; BrTaken = t;
    br_target = g; halt_req = h;
    #2;
    tk = b && t;
    st = (m_slot == 0) && !m_halt && l && !tk;
    if (!r) begin
      // {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted}
      if (m_halt)          e_ctl = 6'b0_0_0_1_1_1;
      else if (m_slot == 1) e_ctl = 6'b1_1_1_1_1_0;
      else if (m_slot > 1)  e_ctl = 6'b1_0_1_1_1_0;
      else                  e_ctl = {!st, 1'b0, !st, 1'b0, st, 1'b0};
      check("ctl", {26'd0, pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted},
            {26'd0, e_ctl});
      check("stall_cnt", {24'd0, stall_cnt}, m_stall);
      check("redirect_cnt", {24'd0, redirect_cnt}, m_redir);
      if (m_slot == 1) check("redirect_pc", {16'd0, redirect_pc}, {16'd0, m_tgt});
    end
    @(posedge clk);
    if (r) begin
      m_slot = 0; m_halt = 0; m_pend = 0; m_tgt = '0; m_stall = 0; m_redir = 0;
    end else if (!m_halt) begin
      if (m_slot > 0) begin
        if (m_slot == 1 && m_redir < CMAX) m_redir++;
        if (h) m_pend = 1;
        m_slot = (m_slot >= FS) ? 0 : m_slot + 1;
      end else if (tk) begin
        m_tgt  = g;
        m_slot = 1;
        if (h) m_pend = 1;
      end else begin
        if (st && m_stall < CMAX) m_stall++;
        if (h || m_pend) begin
          m_halt = 1;
          m_pend = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0, 0);
  endtask

  bit          hr;
  logic [15:0] rt;

  initial begin
    reset = 1; load_use_hazard = 0; br_resolved = 0; BrTaken = 0;
    br_target = '0; halt_req = 0;

    cyc(1, 0, 0, 0, 16'h0, 0);
    cyc(1, 0, 0, 0, 16'h0, 0);
    idle(5);
    check("reset_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    check("reset_redirect_cnt", {24'd0, redirect_cnt}, 32'd0);

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 16'h0, 0);
    idle(1);
    check("stall_cnt_3", {24'd0, stall_cnt}, 32'd3);

    cyc(0, 0, 1, 1, 16'h0040, 0);
    check("redir_pc_sel", {31'd0, pc_sel}, 32'd1);
    check("redir_target", {16'd0, redirect_pc}, 32'h0040);
    idle(2);
    check("redirect_cnt_1", {24'd0, redirect_cnt}, 32'd1);

    // Branch coincident with hazard, then a branch offered during FLUSH.
    cyc(0, 1, 1, 1, 16'h1234, 0);
    idle(1);
    cyc(0, 1, 1, 1, 16'hBEEF, 0);
    idle(1);
    check("stall_unchanged", {24'd0, stall_cnt}, 32'd3);
    check("redirect_cnt_2", {24'd0, redirect_cnt}, 32'd2);

    // Halt arriving during REDIRECT is deferred to the first RUN cycle.
    cyc(0, 0, 1, 1, 16'h0100, 0);
    cyc(0, 0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 0, 16'h0, 1);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_pc_we", {31'd0, pc_we}, 32'd0);
    cyc(1, 0, 0, 0, 16'h0, 0);
    idle(1);
    check("halt_cleared", {31'd0, halted}, 32'd0);

    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0, 16'h0, 0);
    check("stall_sat", {24'd0, stall_cnt}, 32'h00FF);

    // Reset landing in the FLUSH slot.
    cyc(0, 0, 1, 1, 16'h0AAA, 0);
    idle(1);
    cyc(1, 0, 0, 0, 16'h0, 0);
    idle(1);
    check("post_reset_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    check("post_reset_idex_flush", {31'd0, idex_flush}, 32'd0);

    hr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        hr = 0;
        cyc(1, 0, 0, 0, 16'h0, 0);
      end else begin
        if ($urandom_range(0, 199) == 0) hr = 1;
        rt = 16'($urandom);
        cyc(0, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 6, rt, hr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
